step_tempo_gen: RTL and testbench

- Upstream timing source for the per-speaker beat players. Replaces the free-running divided beat clock with a one-cycle `beat_tick` enable in the `clock` domain, plus a shared 16-step beat index.
- Tempo is user-adjustable in BPM. Step period is recomputed by an iterative sequential divider whenever tempo changes.
- Sits between the board key/switch conditioning and all speaker-play instances. Those instances advance on `beat_tick` and read `beat`.

---
 rtl/step_tempo_gen_pkg.sv | 24 ++
 rtl/step_tempo_gen_divider.sv | 67 ++++++
 rtl/step_tempo_gen.sv | 121 ++++++++++++
 tb/tb_step_tempo_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/step_tempo_gen_pkg.sv
// Shared definitions for the step/tempo generator and the speaker-play instances
// that size their beat index from STEP_W.
package step_tempo_gen_pkg;

  localparam int unsigned STEP_W       = 4;
  localparam int unsigned DEF_MIN_BPM  = 60;
  localparam int unsigned DEF_MAX_BPM  = 240;
  localparam int unsigned DEF_BPM_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Clock cycles per minute divided by steps per beat; period = NUM / bpm.
  function automatic logic [31:0] calc_num(input int unsigned clk_hz,
                                           input int unsigned steps_per_beat);
    logic [63:0] w_num;
    w_num = (64'(clk_hz) * 64'd60) / 64'(steps_per_beat);
    return w_num[31:0];
  endfunction

endpackage

// File: rtl/step_tempo_gen_divider.sv
// 32-bit restoring unsigned divider, one quotient bit per cycle.
// A start while busy restarts with the new operands and drops the old result.
module seq_divider_u32
  import step_tempo_gen_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient
);

  div_state_t  r_state;
  div_state_t  w_state_nxt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;

  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_DIV;
      ST_DIV: begin
        if (i_start)             w_state_nxt = ST_DIV;
        else if (r_cnt == 5'd31) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = i_start ? ST_DIV : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign w_rem_sh = {r_rem, r_quot[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});

  always_ff @(posedge clock) begin
    if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (r_state == ST_DIV) begin
      r_rem  <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
      r_quot <= {r_quot[30:0], w_ge};
      r_cnt  <= r_cnt + 5'd1;
    end
  end

  assign o_busy     = (r_state == ST_DIV);
  assign o_done     = (r_state == ST_DONE);
  assign o_quotient = r_quot;

endmodule

// File: rtl/step_tempo_gen.sv
// Tempo-controlled step sequencer timebase: one-cycle beat_tick per 16th step
// and a shared 16-step beat index, with the step period recomputed on tempo change.
module step_tempo_gen
  import step_tempo_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned DEFAULT_BPM    = 120,
  parameter int unsigned MIN_BPM        = DEF_MIN_BPM,
  parameter int unsigned MAX_BPM        = DEF_MAX_BPM,
  parameter int unsigned BPM_STEP       = DEF_BPM_STEP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
  input  logic              tempo_up,
  input  logic              tempo_down,
  output logic              beat_tick,
  output logic [STEP_W-1:0] beat,
  output logic [7:0]        tempo_bpm,
  output logic              div_busy
);

  localparam logic [31:0] NUM            = calc_num(CLK_HZ, STEPS_PER_BEAT);
  localparam logic [31:0] DEFAULT_PERIOD = NUM / 32'(DEFAULT_BPM);

  logic              r_restart_q, r_up_q, r_dn_q;
  logic [7:0]        r_bpm;
  logic [31:0]       r_cnt;
  logic [31:0]       r_period;
  logic [31:0]       r_pend_period;
  logic              r_pend_vld;
  logic [STEP_W-1:0] r_beat;
  logic              r_tick;

  logic              w_restart_edge, w_up_edge, w_dn_edge;
  logic [8:0]        w_up_sum;
  logic [7:0]        w_bpm_up, w_bpm_dn, w_bpm_nxt;
  logic              w_bpm_change;
  logic              w_boundary;
  logic              w_div_busy, w_div_done;
  logic [31:0]       w_quot;

  assign w_restart_edge = restart & ~r_restart_q;
  assign w_up_edge      = tempo_up & ~r_up_q;
  assign w_dn_edge      = tempo_down & ~r_dn_q;

  assign w_up_sum = {1'b0, r_bpm} + 9'(BPM_STEP);
  assign w_bpm_up = (w_up_sum > 9'(MAX_BPM)) ? 8'(MAX_BPM) : w_up_sum[7:0];
  assign w_bpm_dn = ({1'b0, r_bpm} < 9'(MIN_BPM + BPM_STEP)) ? 8'(MIN_BPM)
                                                             : r_bpm - 8'(BPM_STEP);

  // Simultaneous up and down presses cancel each other.
  always_comb begin
    w_bpm_nxt = r_bpm;
    if (w_up_edge && !w_dn_edge)      w_bpm_nxt = w_bpm_up;
    else if (w_dn_edge && !w_up_edge) w_bpm_nxt = w_bpm_dn;
  end

  assign w_bpm_change = (w_bpm_nxt != r_bpm);
  assign w_boundary   = run && (r_cnt == r_period - 32'd1);

  seq_divider_u32 u_div (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_bpm_change),
    .i_dividend (NUM),
    .i_divisor  ({24'd0, w_bpm_nxt}),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_restart_q <= 1'b0;
      r_up_q      <= 1'b0;
      r_dn_q      <= 1'b0;
      r_bpm       <= 8'(DEFAULT_BPM);
      r_cnt       <= '0;
      r_period    <= DEFAULT_PERIOD;
      r_pend_vld  <= 1'b0;
      r_beat      <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_restart_q <= restart;
      r_up_q      <= tempo_up;
      r_dn_q      <= tempo_down;
      r_bpm       <= w_bpm_nxt;
      r_tick      <= w_boundary && !w_restart_edge;

      // A fresh result wins over consuming the older one at a coincident boundary.
      if (w_div_done)
        r_pend_vld <= 1'b1;
      else if (w_boundary && !w_restart_edge)
        r_pend_vld <= 1'b0;

      if (w_restart_edge) begin
        r_cnt  <= '0;
        r_beat <= '0;
      end else if (w_boundary) begin
        r_cnt  <= '0;
        r_beat <= r_beat + STEP_W'(1);
        if (r_pend_vld) r_period <= r_pend_period;
      end else if (run) begin
        r_cnt  <= r_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_div_done) r_pend_period <= w_quot;
  end

  assign beat_tick = r_tick;
  assign beat      = r_beat;
  assign tempo_bpm = r_bpm;
  assign div_busy  = w_div_busy;

endmodule

// File: tb/tb_step_tempo_gen.sv
// Scoreboard bench for step_tempo_gen at CLK_HZ=4800, STEPS_PER_BEAT=4 (NUM=72000).
// Stimulus queues expected ticks (beat, gap in cycles); the monitor checks each tick.
module tb_step_tempo_gen;

  logic       clock = 1'b0;
  logic       reset, run, restart, tempo_up, tempo_down;
  logic       beat_tick;
  logic [3:0] beat;
  logic [7:0] tempo_bpm;
  logic       div_busy;

  always #5 clock = ~clock;

  step_tempo_gen #(
    .CLK_HZ         (4800),
    .STEPS_PER_BEAT (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .restart    (restart),
    .tempo_up   (tempo_up),
    .tempo_down (tempo_down),
    .beat_tick  (beat_tick),
    .beat       (beat),
    .tempo_bpm  (tempo_bpm),
    .div_busy   (div_busy)
  );

  typedef struct {
    logic [3:0] beat;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   n_total   = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   ref_cyc   = 0;
  int   last_tick = 0;
  int   cur_beat  = 0;
  logic restart_q = 1'b0;

  // Reset and restart edges re-zero the step counter, so they restart gap timing.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset || (restart && !restart_q)) ref_cyc <= cyc + 1;
    restart_q <= reset ? 1'b0 : restart;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    int   base;
    if (beat_tick) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_tick: got tick at cycle %0d beat %0d, expected none", cyc, beat);
      end else begin
        e    = q.pop_front();
        base = (ref_cyc > last_tick) ? ref_cyc : last_tick;
        chk("tick_beat", beat, e.beat);
        chk("tick_gap", cyc - base, e.gap);
      end
      last_tick = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_tick(input int gap);
    exp_t e;
    cur_beat = (cur_beat + 1) % 16;
    e.beat   = 4'(cur_beat);
    e.gap    = gap;
    q.push_back(e);
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!beat_tick && n < limit);
    if (!beat_tick) begin
      n_total++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", limit);
    end
  endtask

  task automatic expect_ticks(input int k, input int gap);
    int n;
    for (int i = 0; i < k; i++) begin
      push_tick(gap);
      wait_tick(gap + 50, n);
    end
  endtask

  task automatic press_up();
    tempo_up = 1'b1; step(1);
    tempo_up = 1'b0; step(1);
  endtask

  task automatic press_dn();
    tempo_down = 1'b1; step(1);
    tempo_down = 1'b0; step(1);
  endtask

  task automatic wait_div_idle();
    int k;
    k = 0;
    while (div_busy && k < 60) begin
      step(1);
      k++;
    end
    chk("div_busy_drop", div_busy, 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int hold;
    reset = 1'b1; run = 1'b1; restart = 1'b0; tempo_up = 1'b0; tempo_down = 1'b0;
    step(3);
    chk("rst_beat", beat, 0);
    chk("rst_tick", beat_tick, 0);
    chk("rst_tempo", tempo_bpm, 120);
    chk("rst_busy", div_busy, 0);
    reset = 1'b0;

    // Default tempo: 600-cycle steps, beat wraps 15 -> 0.
    expect_ticks(17, 600);

    // Pause at count 250 for 1000 cycles; 350 cycles remain after resume.
    hold = cur_beat;
    step(250);
    run = 1'b0;
    step(1000);
    chk("pause_beat_hold", beat, hold);
    chk("pause_no_tick", beat_tick, 0);
    run = 1'b1;
    push_tick(1600);
    wait_tick(400, n);
    chk("resume_latency", n, 350);

    // Four ups -> 136 BPM, period 529 after the in-progress 600 step.
    repeat (4) press_up();
    chk("div_busy_up", div_busy, 1);
    chk("tempo_136", tempo_bpm, 136);
    wait_div_idle();
    expect_ticks(1, 600);
    expect_ticks(2, 529);

    // Saturate at 240 (period 300), then at 60 (period 1200).
    repeat (40) press_up();
    chk("tempo_max", tempo_bpm, 240);
    expect_ticks(1, 529);
    expect_ticks(2, 300);
    tempo_up = 1'b1; step(1);
    chk("sat_press_tempo", tempo_bpm, 240);
    chk("sat_press_nodiv", div_busy, 0);
    tempo_up = 1'b0; step(1);
    repeat (50) press_dn();
    chk("tempo_min", tempo_bpm, 60);
    expect_ticks(1, 300);
    expect_ticks(2, 1200);

    // Coincident up/down ignored; second press during DIV wins (72000/68 = 1058).
    tempo_up = 1'b1; tempo_down = 1'b1; step(1);
    chk("both_tempo", tempo_bpm, 60);
    chk("both_nodiv", div_busy, 0);
    tempo_up = 1'b0; tempo_down = 1'b0; step(1);
    tempo_up = 1'b1; step(1);
    tempo_up = 1'b0; step(3);
    chk("div_busy_first", div_busy, 1);
    press_up();
    chk("tempo_68", tempo_bpm, 68);
    expect_ticks(1, 1200);
    expect_ticks(2, 1058);

    // Restart edge lands exactly on the boundary that would make beat 7.
    while (cur_beat != 6) expect_ticks(1, 1058);
    step(1057);
    restart = 1'b1;
    step(1);
    chk("restart_beat", beat, 0);
    chk("restart_no_tick", beat_tick, 0);
    restart = 1'b0;
    cur_beat = 0;
    expect_ticks(1, 1058);

    // Reset while dividing: everything back to reset values, period 600.
    press_up();
    step(3);
    chk("div_busy_mid", div_busy, 1);
    reset = 1'b1;
    step(1);
    chk("rst2_beat", beat, 0);
    chk("rst2_tick", beat_tick, 0);
    chk("rst2_tempo", tempo_bpm, 120);
    chk("rst2_busy", div_busy, 0);
    reset = 1'b0;
    cur_beat = 0;
    expect_ticks(1, 600);

    step(2);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
